// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, state and
// instruction-class enums, and the datapath select encodings.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_JAL     = 6'h03;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXE,
        S_MEM,
        S_WB,
        S_BR,
        S_JAL,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_ORI,
        C_LW,
        C_SW,
        C_BEQ,
        C_JAL,
        C_BAD
    } iclass_t;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MDR   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] GPR_RD   = 2'b00;
    localparam logic [1:0] GPR_RT   = 2'b01;
    localparam logic [1:0] GPR_RA   = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control/datapath bundle: instruction fields and status in, select and strobe
// signals out. The controller takes the slave side, the datapath the master side.
interface mc_ctrl_if;

    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemRdy;

    logic       MemRd;
    logic       DMWr;
    logic       IorD;
    logic       IRWr;
    logic       PCWr;
    logic       RFWr;
    logic       Bsel;
    logic [1:0] WDSel;
    logic [1:0] NPCOp;
    logic [1:0] EXTOp;
    logic [1:0] ALUOp;
    logic [1:0] GPRSel;
    logic       Retire;
    logic       Illegal;

    modport slave (
        input  OP, Funct, Zero, MemRdy,
        output MemRd, DMWr, IorD, IRWr, PCWr, RFWr, Bsel,
               WDSel, NPCOp, EXTOp, ALUOp, GPRSel, Retire, Illegal
    );

    modport master (
        output OP, Funct, Zero, MemRdy,
        input  MemRd, DMWr, IorD, IRWr, PCWr, RFWr, Bsel,
               WDSel, NPCOp, EXTOp, ALUOp, GPRSel, Retire, Illegal
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; anything not in the supported set
// falls into C_BAD so the controller can trap on it.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        iclass = C_BAD;
        case (op)
            OP_RTYPE: begin
                if (funct == FUNCT_ADDU || funct == FUNCT_SUBU) begin
                    iclass = C_RTYPE;
                end
            end
            OP_ORI:  iclass = C_ORI;
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_BEQ:  iclass = C_BEQ;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_BAD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Outputs are combinational decodes of the
// registered state (plus MemRdy/Zero/class), so reset silences them at once.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.slave   bus
);

    state_t  state;
    iclass_t iclass_q;
    iclass_t iclass_d;
    logic    mem_op;

    mc_decode u_decode (
        .op     (bus.OP),
        .funct  (bus.Funct),
        .iclass (iclass_d)
    );

    assign mem_op = (iclass_q == C_LW) || (iclass_q == C_SW);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // The class register resets to C_BAD so a stray MEM/WB decode can never act on stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            iclass_q <= C_BAD;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (bus.MemRdy) state <= S_DECODE;
                S_DECODE: begin
                    iclass_q <= iclass_d;
                    case (iclass_d)
                        C_BEQ:   state <= S_BR;
                        C_JAL:   state <= S_JAL;
                        C_BAD:   state <= S_TRAP;
                        default: state <= S_EXE;
                    endcase
                end
                S_EXE:    state <= mem_op ? S_MEM : S_WB;
                S_MEM: begin
                    if (bus.MemRdy) begin
                        state <= (iclass_q == C_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB, S_BR, S_JAL: state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.MemRd   = 1'b0;
        bus.DMWr    = 1'b0;
        bus.IorD    = 1'b0;
        bus.IRWr    = 1'b0;
        bus.PCWr    = 1'b0;
        bus.RFWr    = 1'b0;
        bus.Bsel    = 1'b0;
        bus.WDSel   = WD_ALU;
        bus.NPCOp   = NPC_PC4;
        bus.EXTOp   = EXT_ZERO;
        bus.ALUOp   = ALU_ADD;
        bus.GPRSel  = GPR_RD;
        bus.Retire  = 1'b0;
        bus.Illegal = 1'b0;

        // ALU setup is shared by EXE and MEM so the address stays stable during a stalled access.
        if (state == S_EXE || state == S_MEM) begin
            case (iclass_q)
                C_RTYPE: begin
                    bus.Bsel  = 1'b0;
                    bus.ALUOp = (bus.Funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
                end
                C_ORI: begin
                    bus.Bsel  = 1'b1;
                    bus.EXTOp = EXT_ZERO;
                    bus.ALUOp = ALU_OR;
                end
                C_LW, C_SW: begin
                    bus.Bsel  = 1'b1;
                    bus.EXTOp = EXT_SIGN;
                    bus.ALUOp = ALU_ADD;
                end
                default: ;
            endcase
        end

        case (state)
            S_FETCH: begin
                bus.MemRd = 1'b1;
                if (bus.MemRdy) begin
                    bus.IRWr  = 1'b1;
                    bus.PCWr  = 1'b1;
                    bus.NPCOp = NPC_PC4;
                end
            end
            S_MEM: begin
                bus.IorD = 1'b1;
                if (iclass_q == C_LW) begin
                    bus.MemRd = 1'b1;
                end else if (iclass_q == C_SW) begin
                    bus.DMWr   = 1'b1;
                    bus.Retire = bus.MemRdy;
                end
            end
            S_WB: begin
                bus.RFWr   = 1'b1;
                bus.Retire = 1'b1;
                case (iclass_q)
                    C_LW: begin
                        bus.WDSel  = WD_MDR;
                        bus.GPRSel = GPR_RT;
                    end
                    C_ORI: begin
                        bus.WDSel  = WD_ALU;
                        bus.GPRSel = GPR_RT;
                    end
                    default: begin
                        bus.WDSel  = WD_ALU;
                        bus.GPRSel = GPR_RD;
                    end
                endcase
            end
            S_BR: begin
                bus.Bsel   = 1'b0;
                bus.ALUOp  = ALU_SUB;
                bus.EXTOp  = EXT_SIGN;
                bus.Retire = 1'b1;
                if (bus.Zero) begin
                    bus.PCWr  = 1'b1;
                    bus.NPCOp = NPC_BR;
                end
            end
            S_JAL: begin
                bus.RFWr   = 1'b1;
                bus.WDSel  = WD_PC;
                bus.GPRSel = GPR_RA;
                bus.PCWr   = 1'b1;
                bus.NPCOp  = NPC_JMP;
                bus.Retire = 1'b1;
            end
            S_TRAP:  bus.Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
